// File: rtl/tff_seq_ctrl.sv
// Command sequencer for an external bank of T flip-flops: turns CLEAR/LOAD/UP/DOWN
// commands into per-cycle toggle vectors computed from the bank's fed-back q.
//
//   state  | meaning
//   S_IDLE | waiting for a command, t_out_o = 0
//   S_EXEC | stepping the bank, one toggle vector per non-held cycle
//   S_DONE | one-cycle completion pulse, no new command accepted
module tff_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [1:0]       cmd_op_i,
  input  logic [CNT_W-1:0] cmd_arg_i,
  input  logic             hold_i,
  input  logic [WIDTH-1:0] q_in_i,
  output logic [WIDTH-1:0] t_out_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_CLEAR = 2'd0;
  localparam logic [1:0] OP_LOAD  = 2'd1;
  localparam logic [1:0] OP_UP    = 2'd2;
  localparam logic [1:0] OP_DOWN  = 2'd3;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [CNT_W-1:0] arg_q, arg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, busy_q;

  logic [WIDTH-1:0] up_t, dn_t;
  logic             run_up, run_dn;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    arg_d   = arg_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          op_d  = cmd_op_i;
          arg_d = cmd_arg_i;
          if (cmd_op_i[1]) begin
            // a zero-length count completes without ever entering EXEC
            cnt_d   = cmd_arg_i;
            state_d = (cmd_arg_i == '0) ? S_DONE : S_EXEC;
          end else begin
            cnt_d   = CNT_W'(1);
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        if (!hold_i) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      arg_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      arg_q   <= arg_d;
      cnt_q   <= cnt_d;
      done_q  <= (state_d == S_DONE);
      busy_q  <= (state_d != S_IDLE);
    end
  end

  // Ripple-carry/borrow toggle masks: bit i flips when all lower bits are 1 (up) or 0 (down).
  always_comb begin
    up_t   = '0;
    dn_t   = '0;
    run_up = 1'b1;
    run_dn = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      up_t[i] = run_up;
      dn_t[i] = run_dn;
      run_up  = run_up & q_in_i[i];
      run_dn  = run_dn & ~q_in_i[i];
    end
  end

  always_comb begin
    t_out_o = '0;
    if (!rst_i && state_q == S_EXEC && !hold_i) begin
      case (op_q)
        OP_CLEAR: t_out_o = q_in_i;
        OP_LOAD:  t_out_o = q_in_i ^ arg_q[WIDTH-1:0];
        OP_UP:    t_out_o = up_t;
        OP_DOWN:  t_out_o = dn_t;
        default:  t_out_o = '0;
      endcase
    end
  end

  generate
    if (CNT_W > WIDTH) begin : g_arg_hi
      logic unused_arg_hi;
      assign unused_arg_hi = ^arg_q[CNT_W-1:WIDTH];
    end
  endgenerate

  assign cmd_ready_o = (state_q == S_IDLE) & ~rst_i;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_tff_seq_ctrl.sv
// Bench for tff_seq_ctrl: TFF bank model on the shared clock, an arithmetic reference
// model compared every cycle, directed scenarios with literal expectations, random commands.
module tb_tff_seq_ctrl;
  localparam int W  = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'd0;
  logic [CW-1:0] cmd_arg = '0;
  logic          hold = 1'b0;
  logic [W-1:0]  bank = '0;
  logic [W-1:0]  t_out;
  logic          busy, done;
  logic          preset_en = 1'b0;
  logic [W-1:0]  preset_val = '0;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  tff_seq_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_op_i    (cmd_op),
    .cmd_arg_i   (cmd_arg),
    .hold_i      (hold),
    .q_in_i      (bank),
    .t_out_o     (t_out),
    .busy_o      (busy),
    .done_o      (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) bank <= preset_en ? preset_val : (bank ^ t_out);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: the bank as a number, commands as target values, a step budget.
  int           m_mode = 0;  // 0 idle, 1 executing, 2 completion cycle
  logic [1:0]   m_op = 2'd0;
  logic [W-1:0] m_tgt = '0;
  int           m_left = 0;
  logic [W-1:0] m_bank = '0;

  function automatic logic [W-1:0] next_val(input logic [1:0] op, input logic [W-1:0] tgt,
                                            input logic [W-1:0] b);
    case (op)
      2'd0:    return '0;
      2'd1:    return tgt;
      2'd2:    return b + 4'd1;
      default: return b - 4'd1;
    endcase
  endfunction

  always @(negedge clk) begin
    logic [W-1:0] t_exp;
    logic         rdy_exp;
    #2;
    t_exp = '0;
    if (!rst && m_mode == 1 && !hold) t_exp = m_bank ^ next_val(m_op, m_tgt, m_bank);
    rdy_exp = (m_mode == 0) && !rst;
    if (chk_en) begin
      chk("model_t_out", 32'(t_out), 32'(t_exp));
      chk("model_cmd_ready", 32'(cmd_ready), 32'(rdy_exp));
      chk("model_busy", 32'(busy), 32'(m_mode != 0));
      chk("model_done", 32'(done), 32'(m_mode == 2));
      chk("model_bank", 32'(bank), 32'(m_bank));
    end
    if (preset_en) m_bank = preset_val;
    else           m_bank = m_bank ^ t_exp;
    if (rst) m_mode = 0;
    else begin
      case (m_mode)
        0: if (cmd_valid) begin
             m_op   = cmd_op;
             m_tgt  = cmd_arg[W-1:0];
             m_left = cmd_op[1] ? int'(cmd_arg) : 1;
             m_mode = (m_left == 0) ? 2 : 1;
           end
        1: if (!hold) begin
             m_left--;
             if (m_left == 0) m_mode = 2;
           end
        default: m_mode = 0;
      endcase
    end
  end

  task automatic preset(input logic [W-1:0] v);
    @(negedge clk);
    preset_en = 1'b1;
    preset_val = v;
    @(negedge clk);
    preset_en = 1'b0;
  endtask

  // Returns 1 ns into the cycle right after the accept edge.
  task automatic send(input logic [1:0] op, input logic [CW-1:0] arg, output int c0);
    int n;
    n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg; hold = 1'b0;
    #1;
    while (!cmd_ready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    chk("accept_timeout", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = 2'($urandom_range(0, 3)); cmd_arg = CW'($urandom);
    #1;
    c0 = cyc;
  endtask

  task automatic wait_done(input bit rnd_hold, output int dcyc, output int holds);
    int n;
    n = 0;
    holds = 0;
    while (!done && n < 400) begin
      @(negedge clk);
      hold = rnd_hold ? ($urandom_range(0, 3) == 0) : 1'b0;
      #1;
      if (hold && !done) holds++;
      n++;
    end
    chk("done_timeout", 32'(done), 32'd1);
    dcyc = cyc;
  endtask

  initial begin
    int c0, cd, hc, steps;
    logic [1:0]    op;
    logic [CW-1:0] arg;
    logic [W-1:0]  start, want;

    // reset with a command waiting and the bank preset
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_arg = 8'd5;
    @(posedge clk);
    chk_en = 1'b1;
    preset(4'b1010);
    repeat (3) begin
      @(negedge clk); #1;
      chk("rst_t_out", 32'(t_out), 32'd0);
      chk("rst_ready", 32'(cmd_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_bank", 32'(bank), 32'b1010);
    end
    @(negedge clk);
    rst = 1'b0; cmd_valid = 1'b0;

    // LOAD 0110 from 1010
    send(2'd1, 8'h06, c0);
    chk("load_t_out", 32'(t_out), 32'b1100);
    wait_done(1'b0, cd, hc);
    chk("load_latency", 32'(cd - c0 + 1), 32'd2);
    chk("load_bank", 32'(bank), 32'b0110);
    chk("load_ready_in_done", 32'(cmd_ready), 32'd0);
    @(negedge clk); #1;
    chk("load_ready_after", 32'(cmd_ready), 32'd1);

    // UP 18 from 1110, wrapping past all-ones
    preset(4'b1110);
    send(2'd2, 8'd18, c0);
    chk("up18_first_t", 32'(t_out), 32'b0001);
    wait_done(1'b0, cd, hc);
    chk("up18_latency", 32'(cd - c0 + 1), 32'd19);
    chk("up18_bank", 32'(bank), 32'b0000);

    // DOWN 3 from 0001, held for two cycles after the first step
    preset(4'b0001);
    send(2'd3, 8'd3, c0);
    chk("down_first_t", 32'(t_out), 32'b0001);
    repeat (2) begin
      @(negedge clk); hold = 1'b1; #1;
      chk("down_held_t", 32'(t_out), 32'd0);
      chk("down_held_bank", 32'(bank), 32'b0000);
    end
    @(negedge clk); hold = 1'b0; #1;
    chk("down_borrow_t", 32'(t_out), 32'b1111);
    wait_done(1'b0, cd, hc);
    chk("down_latency", 32'(cd - c0 + 1), 32'd6);
    chk("down_bank", 32'(bank), 32'b1110);

    // UP 0: immediate completion, no toggles
    send(2'd2, 8'd0, c0);
    chk("up0_done", 32'(done), 32'd1);
    chk("up0_t_out", 32'(t_out), 32'd0);
    wait_done(1'b0, cd, hc);
    chk("up0_latency", 32'(cd - c0 + 1), 32'd1);
    chk("up0_bank", 32'(bank), 32'b1110);

    // CLEAR from 1011
    preset(4'b1011);
    send(2'd0, 8'h5A, c0);
    chk("clear_t_out", 32'(t_out), 32'b1011);
    wait_done(1'b0, cd, hc);
    chk("clear_bank", 32'(bank), 32'b0000);

    // reset after four steps of UP 10 from 0011
    preset(4'b0011);
    send(2'd2, 8'd10, c0);
    repeat (4) @(negedge clk);
    rst = 1'b1; #1;
    chk("midrst_bank", 32'(bank), 32'b0111);
    chk("midrst_t_out", 32'(t_out), 32'd0);
    @(negedge clk); #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_bank_frozen", 32'(bank), 32'b0111);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("postrst_ready", 32'(cmd_ready), 32'd1);
    chk("postrst_done", 32'(done), 32'd0);
    send(2'd1, 8'hFC, c0);
    wait_done(1'b0, cd, hc);
    chk("postrst_load_bank", 32'(bank), 32'b1100);

    // random commands with random holds
    repeat (40) begin
      if ($urandom_range(0, 2) == 0) preset(W'($urandom));
      op  = 2'($urandom_range(0, 3));
      arg = op[1] ? CW'($urandom_range(0, 24)) : CW'($urandom);
      start = bank;
      case (op)
        2'd0:    want = '0;
        2'd1:    want = arg[W-1:0];
        2'd2:    want = W'((int'(start) + int'(arg)) % 16);
        default: want = W'(((int'(start) - int'(arg)) % 16 + 16) % 16);
      endcase
      steps = op[1] ? int'(arg) : 1;
      send(op, arg, c0);
      wait_done(1'b1, cd, hc);
      chk("rnd_latency", 32'(cd - c0), 32'(steps + hc));
      chk("rnd_bank", 32'(bank), 32'(want));
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tff_seq_ctrl.md
Name: tff_seq_ctrl

Overview:
- Sequencer for an external bank of WIDTH T flip-flops (one `T` input and one `q` output per bit).
- Accepts one command at a time: CLEAR, LOAD, UP, or DOWN count.
- Each cycle it computes the per-bit toggle vector `t_out` from its own state and the bank's fed-back `q_in`, and signals completion with a one-cycle `done` pulse.
- Sits between the command source and the TFF bank. The TFF bank stays a pure storage/toggle resource.

Parameters:
- WIDTH, 4, number of TFF bits driven and observed.
- CNT_W, 8, width of `cmd_arg` and the internal step counter. Must be >= WIDTH.

Ports:
- clk  input  1  rising-edge clock, shared with the TFF bank
- rst  input  1  synchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  controller can accept a command
- cmd_op  input  2  00 CLEAR, 01 LOAD, 10 UP, 11 DOWN
- cmd_arg  input  CNT_W  LOAD: target value in bits [WIDTH-1:0]; UP/DOWN: step count N; CLEAR: ignored
- hold  input  1  pause stepping while in EXEC
- q_in  input  WIDTH  current `q` vector of the TFF bank
- t_out  output  WIDTH  `T` vector to the TFF bank; Mealy, combinational from state and `q_in`
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse, registered

Behaviour:
- States: IDLE, EXEC, DONE.
  - Registers: state, op_r (2 bits), arg_r (CNT_W bits), remaining step count cnt (CNT_W bits).
- Reset (`rst`=1 at an edge):
  - state goes to IDLE; op_r, arg_r and cnt are cleared.
  - `done`=0 and `busy`=0.
  - While `rst`=1, `t_out` is forced to 0 and `cmd_ready`=0.
  - Reset mid-operation abandons the command. The TFF bank keeps whatever value it had reached; there is no rollback.
- Handshake:
  - `cmd_ready` = (state==IDLE) & !rst.
  - A command is accepted at an edge where `cmd_valid` & `cmd_ready`; op/arg are latched.
  - Commands presented while busy are not accepted. The source must hold `cmd_valid` until accepted.
- IDLE:
  - `t_out`=0.
  - On accept of UP or DOWN with N=0, go directly to DONE; no toggles occur.
  - On any other accept, go to EXEC with cnt=N for UP/DOWN, cnt=1 for CLEAR/LOAD.
- EXEC, with `hold`=0, `t_out` per op:
  - CLEAR: `t_out` = `q_in`, so bits at 1 toggle to 0.
  - LOAD: `t_out` = `q_in` ^ arg_r[WIDTH-1:0].
  - UP: t[0]=1; t[i] = AND of `q_in`[i-1:0].
  - DOWN: t[0]=1; t[i] = AND of ~`q_in`[i-1:0].
  - Each non-held EXEC cycle decrements cnt at the edge. When cnt==1 at that edge, go to DONE.
- EXEC, with `hold`=1: `t_out`=0, cnt unchanged, stay in EXEC. `hold` is ignored in IDLE and DONE.
- DONE: `t_out`=0, `done`=1 for exactly one cycle, then IDLE.
  - `cmd_ready`=0 in DONE, so the earliest next accept is the cycle after DONE.
- Latency (from the accept edge, no hold):
  - CLEAR/LOAD: bank updated at edge +1; `done` is high in the cycle after edge +1.
  - UP/DOWN with N: bank advanced N times by edge +N; `done` is high in the cycle after edge +N.
  - Each held cycle adds one cycle.
- Arithmetic and wrap:
  - The bank value wraps modulo 2^WIDTH naturally (UP from all-ones gives 0; DOWN from 0 gives all-ones).
  - N may exceed 2^WIDTH; counting continues with wrap.
- LOAD with target == current `q_in`: `t_out`=0 for the single EXEC cycle; still takes 1 cycle and pulses `done`.
- `q_in` is assumed to be the bank's registered output with no combinational path back to `t_out`'s source. The bank must not be driven by any other agent.

Test Plan (WIDTH=4, CNT_W=8, 10 ns clock; TFF bank model instantiated with the same clk):
- Reset with `cmd_valid` high and the bank preset to 4'b1010 -> `t_out`=0, `cmd_ready`=0, `busy`=0, `done`=0 throughout reset; bank stays 1010.
- LOAD 4'b0110 from 4'b1010 -> `t_out`=4'b1100 for one cycle; bank=0110; `done` pulse in the next cycle; `cmd_ready` returns one cycle after `done`.
- UP N=18 from 4'b1110 -> bank sequence 1111, 0000, 0001, …, ending at 0000 (14+18 mod 16); `done` 19 cycles after accept.
- DOWN N=3 from 4'b0001 with `hold`=1 for 2 cycles after the first step -> bank 0000, then held for 2 cycles, then 1111, 1110; `done` 6 cycles after accept.
- UP N=0 -> `t_out` stays 0; `done` in the cycle after accept; bank unchanged.
- CLEAR from 4'b1011, with `rst` asserted mid-UP (N=10) after 4 steps on a separate run -> CLEAR gives `t_out`=1011 and bank=0000; the reset run goes to IDLE with bank frozen at start+4, no `done`, and the next command is accepted normally.
